// File: rtl/s3_writeback_regfile.sv
// s3_writeback_regfile
//
// Consumer end of the S3 writeback path. Commits the S3 ALU result into a
// 2**ADDR_W x DATA_W architectural register file and serves two combinational
// read ports to the decode/S1 operand fetch. Register 0 is hardwired to zero.
// Also tracks which registers have been written since reset and counts
// committed writes (saturating at 16'hFFFF).
//
// Build option:
//   REGFILE_WRITE_BYPASS_EN - when defined, a read of the register being
//   committed this cycle returns S3_WriteData (write-first forwarding).
//   When undefined, reads return the stored contents only.
//
// Ports:
//   clk             pipeline clock; writes on rising edge
//   rst             asynchronous, active-high reset
//   S3_WriteEnable  writeback enable from S3
//   S3_WriteSelect  destination register from S3
//   S3_WriteData    writeback value (S3 ALUOut)
//   ReadSelect1/2   source register selects
//   ReadData1/2     combinational register values
//   WrittenMask     bit i set once register i has been written (bit 0 stays 0)
//   WriteCount      committed writes since reset, saturating

module s3_writeback_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   S3_WriteEnable,
  input  logic [ADDR_W-1:0]      S3_WriteSelect,
  input  logic [DATA_W-1:0]      S3_WriteData,
  input  logic [ADDR_W-1:0]      ReadSelect1,
  input  logic [ADDR_W-1:0]      ReadSelect2,
  output logic [DATA_W-1:0]      ReadData1,
  output logic [DATA_W-1:0]      ReadData2,
  output logic [2**ADDR_W-1:0]   WrittenMask,
  output logic [15:0]            WriteCount
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  written_q;
  logic [15:0]       count_q;
  logic              commit;

  // Writes to register 0 are dropped entirely: no data, no mask bit, no count.
  assign commit = S3_WriteEnable && (S3_WriteSelect != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      written_q <= '0;
      count_q   <= '0;
    end else if (commit) begin
      regs_q[S3_WriteSelect]    <= S3_WriteData;
      written_q[S3_WriteSelect] <= 1'b1;
      if (count_q != 16'hFFFF) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] sel);
    logic [DATA_W-1:0] val;
    val = '0;
    if (sel != '0) begin
      val = regs_q[sel];
`ifdef REGFILE_WRITE_BYPASS_EN
      // commit already excludes register 0, so forwarding never un-zeros R0.
      if (commit && (sel == S3_WriteSelect)) begin
        val = S3_WriteData;
      end
`endif
    end
    return val;
  endfunction

  always_comb begin
    ReadData1 = read_port(ReadSelect1);
    ReadData2 = read_port(ReadSelect2);
  end

  assign WrittenMask = written_q;
  assign WriteCount  = count_q;

endmodule

// File: tb/tb_s3_writeback_regfile.sv
// Self-checking bench for s3_writeback_regfile: directed literal checks plus a
// randomized run compared every cycle against a behavioural register model.
// Works for both builds (REGFILE_WRITE_BYPASS_EN defined or not).

module tb_s3_writeback_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  ws;
  logic [31:0] wd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] mask;
  logic [15:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  s3_writeback_regfile #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .S3_WriteEnable (we),
    .S3_WriteSelect (ws),
    .S3_WriteData   (wd),
    .ReadSelect1    (rs1),
    .ReadSelect2    (rs2),
    .ReadData1      (rd1),
    .ReadData2      (rd2),
    .WrittenMask    (mask),
    .WriteCount     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  // Behavioural model: an array of values, a set of written indices, a count.
  logic [31:0] m_reg [32];
  logic [31:0] m_mask;
  int          m_count;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] <= 32'h0;
      m_mask  <= 32'h0;
      m_count <= 0;
    end else if (we && ws != 5'd0) begin
      m_reg[ws]  <= wd;
      m_mask[ws] <= 1'b1;
      m_count    <= (m_count >= 65535) ? 65535 : m_count + 1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] s);
    if (s == 5'd0) return 32'h0;
    if (Bypass && we && ws != 5'd0 && s == ws) return wd;
    return m_reg[s];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    check("rd1_model", rd1, exp_rd(rs1));
    check("rd2_model", rd2, exp_rd(rs2));
    check("mask_model", mask, m_mask);
    check("count_model", {16'h0, count}, m_count[31:0]);
  end

  task automatic drive(input logic e, input logic [4:0] s, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    we = e; ws = s; wd = d; rs1 = r1; rs2 = r2;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; ws = 5'd0; wd = 32'h0; rs1 = 5'd5; rs2 = 5'd7;
    // Reset with no clock edge yet.
    #2 rst = 1'b1;
    #1;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    check("reset_mask", mask, 32'h0);
    check("reset_count", {16'h0, count}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic write of R5.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    @(negedge clk);
    check("r5_same_cycle", rd1, Bypass ? 32'hDEADBEEF : 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    @(negedge clk);
    check("r5_read1", rd1, 32'hDEADBEEF);
    check("r5_read2", rd2, 32'hDEADBEEF);
    check("r5_mask", mask, 32'h00000020);
    check("r5_count", {16'h0, count}, 32'd1);

    // R0 guard.
    drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    @(negedge clk);
    check("r0_same_cycle", rd1, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    check("r0_read1", rd1, 32'h0);
    check("r0_read2", rd2, 32'h0);
    check("r0_mask", mask, 32'h00000020);
    check("r0_count", {16'h0, count}, 32'd1);

    // Same-cycle write/read of R7.
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7);
    @(negedge clk);
    check("r7_same_cycle", rd2, Bypass ? 32'hA5A5A5A5 : 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
    @(negedge clk);
    check("r7_next_cycle", rd2, 32'hA5A5A5A5);
    check("r7_count", {16'h0, count}, 32'd2);

    // Enable low.
    drive(1'b0, 5'd9, 32'hFFFFFFFF, 5'd9, 5'd9);
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    @(negedge clk);
    check("we_low_r9", rd1, 32'h0);
    check("we_low_count", {16'h0, count}, 32'd2);
    check("we_low_mask", mask, 32'h000000A0);

    // Reset mid-stream.
    drive(1'b1, 5'd3, 32'h33, 5'd3, 5'd4);
    drive(1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
    drive(1'b1, 5'd5, 32'h55, 5'd3, 5'd4);
    drive(1'b1, 5'd6, 32'h66, 5'd3, 5'd4);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rd1", rd1, 32'h0);
    check("mid_rst_rd2", rd2, 32'h0);
    check("mid_rst_mask", mask, 32'h0);
    check("mid_rst_count", {16'h0, count}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; we = 1'b1; ws = 5'd3; wd = 32'h1; rs1 = 5'd3; rs2 = 5'd6;
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd6);
    @(negedge clk);
    check("post_rst_r3", rd1, 32'h1);
    check("post_rst_r6", rd2, 32'h0);
    check("post_rst_mask", mask, 32'h00000008);
    check("post_rst_count", {16'h0, count}, 32'd1);

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] s;
      s = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 3) != 0), s, $urandom(),
            ($urandom_range(0, 3) == 0) ? s : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? s : 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    // Saturation: enough commits to pass 16'hFFFF.
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    check("sat_count", {16'h0, count}, 32'h0000FFFF);
    check("sat_mask", mask, 32'hFFFFFFFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/s3_writeback_regfile.md
Name: s3_writeback_regfile

Overview:
- Consumer end of the S3 writeback interface: it takes S3_WriteEnable, S3_WriteSelect and the S3 ALU result, and commits the result into a 32x32 architectural register file.
- It provides two asynchronous read ports to the decode/S1 stage.
- Tracks which registers have been written since reset, so the bench and debug logic can check writeback coverage.
- Sits between the S3 pipeline register output and the S1 operand fetch, closing the pipeline loop.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register select width; depth is 2**ADDR_W (32 entries).

Ports:
- clk  input  1  pipeline clock; all writes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- S3_WriteEnable  input  1  writeback enable from S3 stage.
- S3_WriteSelect  input  ADDR_W  destination register from S3 stage.
- S3_WriteData  input  DATA_W  writeback value (S3 ALUOut).
- ReadSelect1  input  ADDR_W  source register A select.
- ReadSelect2  input  ADDR_W  source register B select.
- ReadData1  output  DATA_W  register A value (combinational).
- ReadData2  output  DATA_W  register B value (combinational).
- WrittenMask  output  2**ADDR_W  bit i = 1 once register i has been written since reset (bit 0 always 0).
- WriteCount  output  16  number of committed writes since reset, saturating.

Behaviour:
- Reset (rst=1, asynchronous, takes effect without a clock edge):
  - all 32 registers = 0.
  - WrittenMask = 0.
  - WriteCount = 0.
  - therefore ReadData1 = ReadData2 = 0 while rst is held.
- Write commit:
  - condition: rising clk edge with rst=0, S3_WriteEnable=1 and S3_WriteSelect != 0.
  - effect: reg[S3_WriteSelect] <= S3_WriteData; WrittenMask[S3_WriteSelect] <= 1; WriteCount <= WriteCount+1.
- Register 0:
  - hardwired zero; writes to it are discarded.
  - writes to it do not set a mask bit and do not increment WriteCount.
  - reads of it always return 0, including when bypass is enabled.
- S3_WriteEnable=0: no state change; S3_WriteSelect and S3_WriteData are ignored.
- Read ports:
  - purely combinational from the array (plus bypass, see Optional Feature).
  - zero-cycle read latency.
  - a committed write is visible on the read ports in the cycle after the commit edge.
- Both read ports may select the same register; both return the same value.
- WriteCount saturates at 16'hFFFF; further commits leave it at 16'hFFFF.
- WrittenMask bits are sticky; only reset clears them.
- Reset asserted mid-stream: any write presented in the same cycle is lost, and the array is cleared immediately.
- Reset deasserted: the first commit can occur at the first rising edge after rst falls.
- No X propagation: every output is defined from reset onward.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - if S3_WriteEnable=1, S3_WriteSelect != 0 and ReadSelectN == S3_WriteSelect, then ReadDataN = S3_WriteData in the same cycle (write-first forwarding).
  - this covers the read-after-write hazard between S3 and S1 without a stall.
- Not defined:
  - read ports return the stored array contents only.
  - a same-cycle read of the register being written returns the old value.
  - the new value appears the next cycle.
- Mask and counter behaviour are identical in both builds.

Test Plan:
- Reset: drive rst=1 with no clock edge -> ReadData1/2=0, WrittenMask=0, WriteCount=0 immediately.
- Basic write: write R5=32'hDEADBEEF, then ReadSelect1=5 -> ReadData1=32'hDEADBEEF next cycle; WrittenMask=32'h00000020; WriteCount=1.
- R0 guard: write R0=32'h12345678 with S3_WriteEnable=1, then read R0 on both ports -> 0; WrittenMask bit0=0; WriteCount unchanged.
- Same-cycle write/read of R7 (old value 0, new 32'hA5A5A5A5):
  - with REGFILE_WRITE_BYPASS_EN -> ReadData2=32'hA5A5A5A5 in that cycle.
  - without it -> 0 in that cycle, 32'hA5A5A5A5 next cycle.
- Enable low: S3_WriteEnable=0, select=9, data=32'hFFFFFFFF -> R9 stays 0; WriteCount unchanged.
- Reset mid-stream:
  - write R3..R6 on consecutive cycles, assert rst asynchronously between edges -> all reads 0, WrittenMask=0, WriteCount=0.
  - after rst falls, write R3=32'h1 -> R3=1 and WriteCount=1.
